gmii_tx_framer: RTL
===================

# gmii_tx_framer

Transmit framer on the GMII side of the PCS, directly upstream of the `pcs` transmit path. It takes payload octets from a MAC/packet source over a valid/ready stream and drives `tx_en`/`txd` into `pcs`. It adds a 7-octet preamble and an SFD, streams the payload, and enforces a minimum inter-packet gap. It also flags source underruns and counts completed frames.

## Interface

Parameters:
- `OCTET_WIDTH`, default 8: width of `s_data`/`txd`.
- `PREAMBLE_LEN`, default 7: number of 0x55 octets before the SFD; must be ≥1.
- `IPG_LEN`, default 12: minimum number of cycles with `tx_en` low between frames; must be ≥1.
- `CNT_WIDTH`, default 16: width of `frames_sent`.

Ports:
- `clk` in 1: single clock, rising edge.
- `mr_main_reset` in 1: reset, asynchronous, active-low.
- `s_data` in OCTET_WIDTH: payload octet; ignored unless `s_valid`=1.
- `s_valid` in 1: source has an octet.
- `s_last` in 1: the current octet is the final octet of the frame; qualified by `s_valid`.
- `s_ready` out 1: framer accepts an octet this cycle; combinational, equals (state==DATA).
- `tx_en` out 1: registered GMII transmit enable to `pcs`.
- `txd` out OCTET_WIDTH: registered GMII transmit data to `pcs`.
- `busy` out 1: combinational, equals (state!=IDLE).
- `underrun` out 1: registered one-cycle pulse when a frame is aborted.
- `frames_sent` out CNT_WIDTH: registered count of completed frames; wraps modulo 2^CNT_WIDTH.

## Operation

- States are IDLE, PREAMBLE, DATA and IPG. A counter `cnt` is wide enough for max(PREAMBLE_LEN, IPG_LEN).
- A handshake occurs when `s_valid` & `s_ready` are both 1 at a rising edge. Octets are accepted only in DATA.
- **IDLE:** `tx_en`=0, `txd`=0.
  - On an edge with `s_valid`=1: `txd`<=0x55, `tx_en`<=1, `cnt`<=1, and the state moves to PREAMBLE.
  - No octet is consumed on this edge.
- **PREAMBLE**, on each edge:
  - If `cnt`<PREAMBLE_LEN: `txd`<=0x55 and `cnt`++.
  - Otherwise: `txd`<=0xD5 (SFD) and the state moves to DATA.
- **DATA**, on each edge:
  - On a handshake: `txd`<=`s_data` and `tx_en`<=1.
    - If `s_last`=1, additionally: `frames_sent`++, `cnt`<=0, and the state moves to IPG.
  - If `s_valid`=0, this is an underrun:
    - `tx_en`<=0, `txd`<=0 and `underrun`<=1 for one cycle.
    - `cnt`<=0 and the state moves to IPG.
    - `frames_sent` is unchanged.
  - This rule applies on every DATA edge, including the first. If `s_valid` drops during PREAMBLE, the first DATA edge therefore aborts the frame.
- **IPG**, on each edge:
  - `tx_en`<=0, `txd`<=0, `cnt`++.
  - When `cnt`==IPG_LEN-1, the state moves to IDLE.
- Source contract: `s_data`/`s_last` must be held until the handshake. `s_valid` must stay high from frame start through the last octet. Gaps are not supported; a gap means underrun.
- Reset asserted at any time:
  - Immediately sets: state IDLE, `cnt`=0, `tx_en`=0, `txd`=0, `underrun`=0, `frames_sent`=0.
  - A partially transmitted frame is truncated with no IPG guarantee.
  - After reset is released, the first edge with `s_valid`=1 in IDLE starts a clean frame.

## Timing

- Reset values: `tx_en`=0, `txd`=0, `underrun`=0, `frames_sent`=0, `s_ready`=0, `busy`=0.
- Let E0 be the IDLE edge with `s_valid`=1.
  - 0x55 is on `txd` for the PREAMBLE_LEN cycles after E0.
  - 0xD5 is on `txd` for the cycle after that.
  - Payload octet k appears the cycle after its handshake. With `s_valid` held high, octets are contiguous and octet 0 follows the SFD directly.
- Latency from E0 to the first payload octet on `txd` is PREAMBLE_LEN+1 cycles.
- The last octet is driven for one cycle; `tx_en` then stays low for exactly IPG_LEN cycles before the earliest next preamble (`s_valid` high in IDLE).
- After an underrun, `tx_en` is low for IPG_LEN+1 cycles minimum.
- `frames_sent` updates on the same edge that drives the last octet.
- A frame of N octets occupies `tx_en` high for PREAMBLE_LEN+1+N cycles.

## Test plan

- Reset: drive `mr_main_reset`=0 mid-simulation → all outputs 0 asynchronously (before the next edge), and `busy`=0.
- Single frame 0x11,0x22,0x33,0x44, with `s_valid` continuous and `s_last` on 0x44 → `txd` = 55×7, D5, 11, 22, 33, 44 with `tx_en`=1 for 12 cycles; then 12 low cycles; `frames_sent`=1; `underrun` never pulses.
- Back-to-back: second frame 0xAA,0xBB with `s_valid` held high throughout the IPG → exactly 12 `tx_en`-low cycles between 0x44 and the next 0x55; `frames_sent`=2.
- One-octet frame 0x5A with `s_last`=1 → 55×7, D5, 5A, then `tx_en` low; `frames_sent`+1.
- Underrun: frame 0x01,0x02, then `s_valid`=0 before `s_last` → `tx_en` falls right after 0x02, `underrun` is a single-cycle pulse, `frames_sent` is unchanged, and the next frame starts cleanly after ≥13 low cycles.
- Reset mid-PREAMBLE (at the 3rd 0x55): `tx_en`/`txd` go to 0 immediately. After release, a new frame produces a full 7×0x55 preamble. With CNT_WIDTH=2, five completed frames → `frames_sent`=1 (wrap).

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: prepends preamble + SFD to a valid/ready octet stream,
// enforces a minimum inter-packet gap, flags source underruns and counts frames.
module gmii_tx_framer #(
  parameter int unsigned OCTET_WIDTH  = 8,
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IPG_LEN      = 12,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   mr_main_reset,
  input  logic [OCTET_WIDTH-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   tx_en,
  output logic [OCTET_WIDTH-1:0] txd,
  output logic                   busy,
  output logic                   underrun,
  output logic [CNT_WIDTH-1:0]   frames_sent
);

  localparam int unsigned MaxLen = (PREAMBLE_LEN > IPG_LEN) ? PREAMBLE_LEN : IPG_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0]        PreLenC  = CntW'(PREAMBLE_LEN);
  localparam logic [CntW-1:0]        IpgLastC = CntW'(IPG_LEN - 1);
  localparam logic [OCTET_WIDTH-1:0] PreOct   = OCTET_WIDTH'(8'h55);
  localparam logic [OCTET_WIDTH-1:0] SfdOct   = OCTET_WIDTH'(8'hD5);

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StIpg
  } state_e;

  state_e                 r_state, w_state_nxt;
  logic [CntW-1:0]        r_cnt, w_cnt_nxt;
  logic                   r_tx_en, w_tx_en_nxt;
  logic [OCTET_WIDTH-1:0] r_txd, w_txd_nxt;
  logic                   r_underrun, w_underrun_nxt;
  logic [CNT_WIDTH-1:0]   r_frames, w_frames_nxt;

  // State and registered GMII outputs; reset truncates any frame in flight.
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_tx_en    <= 1'b0;
      r_txd      <= '0;
      r_underrun <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_en    <= w_tx_en_nxt;
      r_txd      <= w_txd_nxt;
      r_underrun <= w_underrun_nxt;
      r_frames   <= w_frames_nxt;
    end
  end

  // Next-state and next-output logic for the framing sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tx_en_nxt    = r_tx_en;
    w_txd_nxt      = r_txd;
    w_underrun_nxt = 1'b0;
    w_frames_nxt   = r_frames;

    case (r_state)
      StIdle: begin
        w_tx_en_nxt = 1'b0;
        w_txd_nxt   = '0;
        // Start of frame: first preamble octet goes out now, nothing consumed.
        if (s_valid) begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = PreOct;
          w_cnt_nxt   = CntW'(1);
          w_state_nxt = StPreamble;
        end
      end

      StPreamble: begin
        if (r_cnt < PreLenC) begin
          w_txd_nxt = PreOct;
          w_cnt_nxt = r_cnt + CntW'(1);
        end else begin
          w_txd_nxt   = SfdOct;
          w_state_nxt = StData;
        end
      end

      StData: begin
        if (s_valid) begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = s_data;
          if (s_last) begin
            w_frames_nxt = r_frames + CNT_WIDTH'(1);
            w_cnt_nxt    = '0;
            w_state_nxt  = StIpg;
          end
        end else begin
          // Source ran dry mid-frame: abort and still honour the gap.
          w_tx_en_nxt    = 1'b0;
          w_txd_nxt      = '0;
          w_underrun_nxt = 1'b1;
          w_cnt_nxt      = '0;
          w_state_nxt    = StIpg;
        end
      end

      StIpg: begin
        w_tx_en_nxt = 1'b0;
        w_txd_nxt   = '0;
        w_cnt_nxt   = r_cnt + CntW'(1);
        if (r_cnt == IpgLastC) begin
          w_state_nxt = StIdle;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign s_ready     = (r_state == StData);
  assign busy        = (r_state != StIdle);
  assign tx_en       = r_tx_en;
  assign txd         = r_txd;
  assign underrun    = r_underrun;
  assign frames_sent = r_frames;

endmodule
